// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the HDR memory request arbiter.
package ram_arb_pkg;

  localparam int DEF_ADDR_W = 25;
  localparam int DEF_DATA_W = 256;

  typedef enum logic [1:0] {SRC_CAM, SRC_HDR_RD, SRC_HDR_WR} src_t;

  typedef enum logic {IDLE, CMD} state_t;

endpackage

// File: rtl/ram_arb_slot.sv
// One-entry request holding register; a load in the same cycle as a clear keeps the new request.
module ram_arb_slot #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              occupied,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupied <= 1'b0;
      addr     <= '0;
      data     <= '0;
    end else if (load) begin
      occupied <= 1'b1;
      addr     <= load_addr;
      data     <= load_data;
    end else if (clear) begin
      occupied <= 1'b0;
    end
  end

endmodule

// File: rtl/ram_request_arbiter.sv
// Serializes camera/HDR requests onto one memory command port and returns reads in order.
// Optional RAM_ARB_PERF_EN adds command and stall counters.
//
// state | meaning
// IDLE  | pick the highest-priority eligible slot and load the command registers
// CMD   | hold mem_cmd_valid with stable fields until mem_cmd_ready
module ram_request_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int RD_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cam_wr_req,
  input  logic [ADDR_W-1:0] cam_wr_address,
  input  logic [DATA_W-1:0] cam_wr_data,
  input  logic              hdr_rd_req,
  input  logic [ADDR_W-1:0] hdr_rd_address,
  input  logic              hdr_wr_req,
  input  logic [ADDR_W-1:0] hdr_wr_address,
  input  logic [DATA_W-1:0] hdr_wr_data,
  output logic              ram_busy,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              cam_overflow,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic              mem_cmd_we,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rdata_valid,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef RAM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_cmd_count,
  output logic [31:0]       perf_stall_cycles
`endif
);

  localparam int OW = $clog2(RD_DEPTH + 1);
  localparam logic [OW-1:0] RD_MAX = OW'(RD_DEPTH);
  localparam logic [OW-1:0] ONE    = OW'(1);

  state_t            state;
  src_t              src;
  logic [OW-1:0]     outstanding, out_nxt;
  logic              cam_occ, rd_occ, wr_occ;
  logic [ADDR_W-1:0] cam_addr, rd_addr, wr_addr;
  logic [DATA_W-1:0] cam_data, rd_slot_data, wr_data;
  logic              cmd_hs, rd_hs, beat;
  logic              cam_clr, rd_clr, wr_clr, cam_load;
  logic              any_occ_nxt;

  assign cmd_hs   = (state == CMD) && mem_cmd_ready;
  assign rd_hs    = cmd_hs && !mem_cmd_we;
  assign cam_clr  = cmd_hs && (src == SRC_CAM);
  assign rd_clr   = cmd_hs && (src == SRC_HDR_RD);
  assign wr_clr   = cmd_hs && (src == SRC_HDR_WR);
  // Camera may refill its slot in the very cycle the slot is handed to memory.
  assign cam_load = cam_wr_req && (!cam_occ || cam_clr);
  // Beats with nothing outstanding are stale (e.g. issued before a reset) and dropped.
  assign beat     = mem_rdata_valid && (outstanding != '0);

  assign any_occ_nxt = cam_load   || (cam_occ && !cam_clr) ||
                       hdr_rd_req || (rd_occ  && !rd_clr)  ||
                       hdr_wr_req || (wr_occ  && !wr_clr);

  ram_arb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cam_slot (
    .clk(clk), .rst(rst), .load(cam_load), .clear(cam_clr),
    .load_addr(cam_wr_address), .load_data(cam_wr_data),
    .occupied(cam_occ), .addr(cam_addr), .data(cam_data)
  );

  ram_arb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_hdr_rd_slot (
    .clk(clk), .rst(rst), .load(hdr_rd_req), .clear(rd_clr),
    .load_addr(hdr_rd_address), .load_data('0),
    .occupied(rd_occ), .addr(rd_addr), .data(rd_slot_data)
  );

  ram_arb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_hdr_wr_slot (
    .clk(clk), .rst(rst), .load(hdr_wr_req), .clear(wr_clr),
    .load_addr(hdr_wr_address), .load_data(hdr_wr_data),
    .occupied(wr_occ), .addr(wr_addr), .data(wr_data)
  );

  always_comb begin
    out_nxt = outstanding;
    case ({rd_hs, beat})
      2'b10:   out_nxt = outstanding + ONE;
      2'b01:   out_nxt = outstanding - ONE;
      default: out_nxt = outstanding;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      src           <= SRC_CAM;
      mem_cmd_valid <= 1'b0;
      mem_cmd_we    <= 1'b0;
      mem_cmd_addr  <= '0;
      mem_wdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cam_occ) begin
            src           <= SRC_CAM;
            mem_cmd_we    <= 1'b1;
            mem_cmd_addr  <= cam_addr;
            mem_wdata     <= cam_data;
            mem_cmd_valid <= 1'b1;
            state         <= CMD;
          end else if (rd_occ && (outstanding < RD_MAX)) begin
            src           <= SRC_HDR_RD;
            mem_cmd_we    <= 1'b0;
            mem_cmd_addr  <= rd_addr;
            mem_wdata     <= rd_slot_data;
            mem_cmd_valid <= 1'b1;
            state         <= CMD;
          end else if (wr_occ) begin
            src           <= SRC_HDR_WR;
            mem_cmd_we    <= 1'b1;
            mem_cmd_addr  <= wr_addr;
            mem_wdata     <= wr_data;
            mem_cmd_valid <= 1'b1;
            state         <= CMD;
          end
        end
        CMD: begin
          if (mem_cmd_ready) begin
            mem_cmd_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding  <= '0;
      ram_busy     <= 1'b0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      cam_overflow <= 1'b0;
    end else begin
      outstanding <= out_nxt;
      ram_busy    <= any_occ_nxt || (out_nxt == RD_MAX);
      rd_valid    <= beat;
      if (beat) rd_data <= mem_rdata;
      if (cam_wr_req && cam_occ && !cam_clr) cam_overflow <= 1'b1;
    end
  end

`ifdef RAM_ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cmd_count    <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (cmd_hs) perf_cmd_count <= perf_cmd_count + 32'd1;
      if (mem_cmd_valid && !mem_cmd_ready) perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_request_arbiter.sv
// Directed bench for ram_request_arbiter; perf counters are checked when RAM_ARB_PERF_EN is defined.
module tb_ram_request_arbiter;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic              cam_wr_req;
  logic [ADDR_W-1:0] cam_wr_address;
  logic [DATA_W-1:0] cam_wr_data;
  logic              hdr_rd_req;
  logic [ADDR_W-1:0] hdr_rd_address;
  logic              hdr_wr_req;
  logic [ADDR_W-1:0] hdr_wr_address;
  logic [DATA_W-1:0] hdr_wr_data;
  logic              ram_busy;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              cam_overflow;
  logic              mem_cmd_valid;
  logic              mem_cmd_ready;
  logic              mem_cmd_we;
  logic [ADDR_W-1:0] mem_cmd_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rdata_valid;
  logic [DATA_W-1:0] mem_rdata;
`ifdef RAM_ARB_PERF_EN
  logic [31:0]       perf_cmd_count;
  logic [31:0]       perf_stall_cycles;
`endif

  int total = 0;
  int bad   = 0;

  ram_request_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cam_wr_req(cam_wr_req), .cam_wr_address(cam_wr_address), .cam_wr_data(cam_wr_data),
    .hdr_rd_req(hdr_rd_req), .hdr_rd_address(hdr_rd_address),
    .hdr_wr_req(hdr_wr_req), .hdr_wr_address(hdr_wr_address), .hdr_wr_data(hdr_wr_data),
    .ram_busy(ram_busy), .rd_valid(rd_valid), .rd_data(rd_data), .cam_overflow(cam_overflow),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_we(mem_cmd_we),
    .mem_cmd_addr(mem_cmd_addr), .mem_wdata(mem_wdata),
    .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata)
`ifdef RAM_ARB_PERF_EN
    , .perf_cmd_count(perf_cmd_count), .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_cmd_valid"}, DATA_W'(mem_cmd_valid), '0);
    chk({tag, "_cmd_we"},    DATA_W'(mem_cmd_we), '0);
    chk({tag, "_cmd_addr"},  DATA_W'(mem_cmd_addr), '0);
    chk({tag, "_wdata"},     mem_wdata, '0);
    chk({tag, "_rd_valid"},  DATA_W'(rd_valid), '0);
    chk({tag, "_rd_data"},   rd_data, '0);
    chk({tag, "_busy"},      DATA_W'(ram_busy), '0);
    chk({tag, "_overflow"},  DATA_W'(cam_overflow), '0);
`ifdef RAM_ARB_PERF_EN
    chk({tag, "_perf_cmd"},   DATA_W'(perf_cmd_count), '0);
    chk({tag, "_perf_stall"}, DATA_W'(perf_stall_cycles), '0);
`endif
  endtask

  // Waits (bounded) at negedges for a presented command.
  task automatic wait_cmd(input string tag, input int budget);
    int n = 0;
    while (mem_cmd_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_cmd_seen"}, DATA_W'(mem_cmd_valid), DATA_W'(1'b1));
  endtask

  // Pulses one HDR read and lets it handshake (mem_cmd_ready must be 1).
  task automatic issue_read(input string tag, input logic [ADDR_W-1:0] a);
    hdr_rd_req = 1'b1;
    hdr_rd_address = a;
    @(negedge clk);
    hdr_rd_req = 1'b0;
    wait_cmd(tag, 4);
    chk({tag, "_we"},   DATA_W'(mem_cmd_we), '0);
    chk({tag, "_addr"}, DATA_W'(mem_cmd_addr), DATA_W'(a));
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [DATA_W-1:0] pat_a5, d_a, d_b, d_c, d_w;
    logic stable, issued;
    pat_a5 = {32{8'hA5}};
    d_a    = {8{32'hCAFE_0001}};
    d_b    = {8{32'hBEEF_0002}};
    d_c    = {8{32'h1357_0003}};
    d_w    = {8{32'h0F0F_0004}};

    rst = 1'b1;
    cam_wr_req = 0; cam_wr_address = '0; cam_wr_data = '0;
    hdr_rd_req = 0; hdr_rd_address = '0;
    hdr_wr_req = 0; hdr_wr_address = '0; hdr_wr_data = '0;
    mem_cmd_ready = 0; mem_rdata_valid = 0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Single HDR read, return three cycles after the handshake
    mem_cmd_ready = 1'b1;
    hdr_rd_req = 1'b1;
    hdr_rd_address = 25'h25800;
    @(negedge clk);
    hdr_rd_req = 1'b0;
    chk("t1_busy_up", DATA_W'(ram_busy), DATA_W'(1'b1));
    chk("t1_no_cmd_yet", DATA_W'(mem_cmd_valid), '0);
    @(negedge clk);
    chk("t1_cmd_valid", DATA_W'(mem_cmd_valid), DATA_W'(1'b1));
    chk("t1_cmd_we", DATA_W'(mem_cmd_we), '0);
    chk("t1_cmd_addr", DATA_W'(mem_cmd_addr), DATA_W'(25'h25800));
    @(negedge clk);
    chk("t1_cmd_drop", DATA_W'(mem_cmd_valid), '0);
    chk("t1_busy_down", DATA_W'(ram_busy), '0);
    repeat (2) @(negedge clk);
    mem_rdata_valid = 1'b1;
    mem_rdata = pat_a5;
    chk("t1_no_early_rd", DATA_W'(rd_valid), '0);
    @(negedge clk);
    mem_rdata_valid = 1'b0;
    chk("t1_rd_valid", DATA_W'(rd_valid), DATA_W'(1'b1));
    chk("t1_rd_data", rd_data, pat_a5);
    @(negedge clk);
    chk("t1_rd_pulse", DATA_W'(rd_valid), '0);

    // CAM write and HDR read together: CAM first
    cam_wr_req = 1'b1; cam_wr_address = 25'h01000; cam_wr_data = d_a;
    hdr_rd_req = 1'b1; hdr_rd_address = 25'h02000;
    @(negedge clk);
    cam_wr_req = 1'b0; hdr_rd_req = 1'b0;
    chk("t2_busy", DATA_W'(ram_busy), DATA_W'(1'b1));
    @(negedge clk);
    chk("t2_first_valid", DATA_W'(mem_cmd_valid), DATA_W'(1'b1));
    chk("t2_first_we", DATA_W'(mem_cmd_we), DATA_W'(1'b1));
    chk("t2_first_addr", DATA_W'(mem_cmd_addr), DATA_W'(25'h01000));
    chk("t2_first_wdata", mem_wdata, d_a);
    @(negedge clk);
    chk("t2_gap", DATA_W'(mem_cmd_valid), '0);
    chk("t2_busy_held", DATA_W'(ram_busy), DATA_W'(1'b1));
    @(negedge clk);
    chk("t2_second_valid", DATA_W'(mem_cmd_valid), DATA_W'(1'b1));
    chk("t2_second_we", DATA_W'(mem_cmd_we), '0);
    chk("t2_second_addr", DATA_W'(mem_cmd_addr), DATA_W'(25'h02000));
    @(negedge clk);
    chk("t2_busy_down", DATA_W'(ram_busy), '0);
    mem_rdata_valid = 1'b1; mem_rdata = 256'h1234;
    @(negedge clk);
    mem_rdata_valid = 1'b0;
    chk("t2_rd_data", rd_data, 256'h1234);

    // HDR read and HDR write together: read first
    hdr_rd_req = 1'b1; hdr_rd_address = 25'h03000;
    hdr_wr_req = 1'b1; hdr_wr_address = 25'h03100; hdr_wr_data = d_w;
    @(negedge clk);
    hdr_rd_req = 1'b0; hdr_wr_req = 1'b0;
    @(negedge clk);
    chk("t2b_rd_first_we", DATA_W'(mem_cmd_we), '0);
    chk("t2b_rd_first_addr", DATA_W'(mem_cmd_addr), DATA_W'(25'h03000));
    repeat (2) @(negedge clk);
    chk("t2b_wr_valid", DATA_W'(mem_cmd_valid), DATA_W'(1'b1));
    chk("t2b_wr_we", DATA_W'(mem_cmd_we), DATA_W'(1'b1));
    chk("t2b_wr_addr", DATA_W'(mem_cmd_addr), DATA_W'(25'h03100));
    chk("t2b_wr_wdata", mem_wdata, d_w);
    @(negedge clk);
    chk("t2b_busy_down", DATA_W'(ram_busy), '0);
    mem_rdata_valid = 1'b1; mem_rdata = 256'h5678;
    @(negedge clk);
    mem_rdata_valid = 1'b0;
    chk("t2b_rd_data", rd_data, 256'h5678);

    // Stalled CAM write: fields stable, second request overflows, refill on the freeing cycle
    pulse_reset();
    mem_cmd_ready = 1'b0;
    cam_wr_req = 1'b1; cam_wr_address = 25'h0AAAA; cam_wr_data = d_a;
    @(negedge clk);
    cam_wr_req = 1'b0;
    wait_cmd("t3", 4);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (mem_cmd_valid !== 1'b1 || mem_cmd_we !== 1'b1 ||
          mem_cmd_addr !== 25'h0AAAA || mem_wdata !== d_a) stable = 1'b0;
      if (i == 3) begin
        cam_wr_req = 1'b1; cam_wr_address = 25'h0BBBB; cam_wr_data = d_b;
      end
      if (i == 4) cam_wr_req = 1'b0;
      @(negedge clk);
    end
    chk("t3_fields_stable", DATA_W'(stable), DATA_W'(1'b1));
    chk("t3_overflow", DATA_W'(cam_overflow), DATA_W'(1'b1));
    mem_cmd_ready = 1'b1;
    cam_wr_req = 1'b1; cam_wr_address = 25'h0CCCC; cam_wr_data = d_c;
    @(negedge clk);
    cam_wr_req = 1'b0;
    chk("t3_after_hs", DATA_W'(mem_cmd_valid), '0);
    chk("t3_busy_refill", DATA_W'(ram_busy), DATA_W'(1'b1));
`ifdef RAM_ARB_PERF_EN
    chk("t3_perf_stall", DATA_W'(perf_stall_cycles), DATA_W'(32'd10));
    chk("t3_perf_cmd", DATA_W'(perf_cmd_count), DATA_W'(32'd1));
`endif
    @(negedge clk);
    chk("t3_refill_valid", DATA_W'(mem_cmd_valid), DATA_W'(1'b1));
    chk("t3_refill_addr", DATA_W'(mem_cmd_addr), DATA_W'(25'h0CCCC));
    chk("t3_refill_wdata", mem_wdata, d_c);
    @(negedge clk);
    chk("t3_busy_down", DATA_W'(ram_busy), '0);
    chk("t3_overflow_sticky", DATA_W'(cam_overflow), DATA_W'(1'b1));

    // Read depth limit
    pulse_reset();
    chk("t4_overflow_cleared", DATA_W'(cam_overflow), '0);
    mem_cmd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      issue_read("t4_rd", ADDR_W'(25'h300 + k));
      chk("t4_busy_after_rd", DATA_W'(ram_busy), DATA_W'((k == 3) ? 1'b1 : 1'b0));
    end
    hdr_rd_req = 1'b1; hdr_rd_address = 25'h304;
    @(negedge clk);
    hdr_rd_req = 1'b0;
    issued = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (mem_cmd_valid === 1'b1) issued = 1'b1;
    end
    chk("t4_fifth_blocked", DATA_W'(issued), '0);
    chk("t4_busy_full", DATA_W'(ram_busy), DATA_W'(1'b1));
    mem_rdata_valid = 1'b1; mem_rdata = 256'h300;
    @(negedge clk);
    mem_rdata_valid = 1'b0;
    chk("t4_ret0_valid", DATA_W'(rd_valid), DATA_W'(1'b1));
    chk("t4_ret0_data", rd_data, 256'h300);
    wait_cmd("t4_fifth", 4);
    chk("t4_fifth_addr", DATA_W'(mem_cmd_addr), DATA_W'(25'h304));
    chk("t4_fifth_we", DATA_W'(mem_cmd_we), '0);
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      mem_rdata_valid = 1'b1;
      mem_rdata = DATA_W'(256'h300 + k);
      @(negedge clk);
      chk("t4_ret_valid", DATA_W'(rd_valid), DATA_W'(1'b1));
      chk("t4_ret_data", rd_data, DATA_W'(256'h300 + k));
    end
    mem_rdata_valid = 1'b0;
    @(negedge clk);
    chk("t4_rd_idle", DATA_W'(rd_valid), '0);
    chk("t4_busy_down", DATA_W'(ram_busy), '0);

    // Reset while in CMD with two reads outstanding, then stray beats
    issue_read("t5_rd0", 25'h400);
    issue_read("t5_rd1", 25'h401);
    mem_cmd_ready = 1'b0;
    cam_wr_req = 1'b1; cam_wr_address = 25'h0DDDD; cam_wr_data = d_b;
    @(negedge clk);
    cam_wr_req = 1'b0;
    wait_cmd("t5", 4);
    rst = 1'b1;
    #1;
    chk("t5_async_clear", DATA_W'(mem_cmd_valid), '0);
    @(negedge clk);
    check_all_zero("t5_reset");
    rst = 1'b0;
    mem_cmd_ready = 1'b1;
    mem_rdata_valid = 1'b1; mem_rdata = {DATA_W{1'b1}};
    @(negedge clk);
    chk("t5_stray0", DATA_W'(rd_valid), '0);
    @(negedge clk);
    mem_rdata_valid = 1'b0;
    chk("t5_stray1", DATA_W'(rd_valid), '0);
    @(negedge clk);
    chk("t5_stray_rd_data", rd_data, '0);
    chk("t5_busy", DATA_W'(ram_busy), '0);
    chk("t5_no_cmd", DATA_W'(mem_cmd_valid), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
